// File: rtl/rpn_pkg.sv
// Shared types and default sizes for the RPN expression sequencer.
package rpn_pkg;

  localparam int DW_DEF        = 16;
  localparam int STK_DEPTH_DEF = 255;
  localparam int CW_DEF        = 9;

  typedef enum logic [1:0] {
    TOK_OPND = 2'd0,
    TOK_OPER = 2'd1,
    TOK_END  = 2'd2,
    TOK_RSVD = 2'd3
  } tok_type_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_UNDER   = 2'd1,
    ERR_OVER    = 2'd2,
    ERR_BAD_END = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP_B  = 3'd1,
    ST_POP_A  = 3'd2,
    ST_PUSH_R = 3'd3,
    ST_SKIP   = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_RESULT = 3'd6
  } state_e;

endpackage

// File: rtl/rpn_sequencer_if.sv
// Token, stack-command and result channels of the RPN sequencer, plus debug taps.
interface rpn_sequencer_if #(
  parameter int DW = rpn_pkg::DW_DEF,
  parameter int CW = rpn_pkg::CW_DEF
);
  // valid/ready: a transfer happens on a rising edge where both are high; the
  // sender holds its payload stable while valid is high and ready is low.
  logic          tok_valid;
  logic          tok_ready;
  logic [1:0]    tok_type;
  logic [2:0]    tok_op;
  logic [DW-1:0] tok_data;

  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_top;

  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [1:0]    res_err;

  logic          busy;
  logic [2:0]    dbg_state;
  logic [CW-1:0] dbg_depth;

  modport master (
    input  tok_valid, tok_type, tok_op, tok_data, stk_top, res_ready,
    output tok_ready, stk_push, stk_pop, stk_din, res_valid, res_data, res_err,
    output busy, dbg_state, dbg_depth
  );

  modport slave (
    output tok_valid, tok_type, tok_op, tok_data, stk_top, res_ready,
    input  tok_ready, stk_push, stk_pop, stk_din, res_valid, res_data, res_err,
    input  busy, dbg_state, dbg_depth
  );
endinterface

// File: rtl/rpn_alu.sv
// Combinational 16-bit ALU for the RPN sequencer; a is the older entry, b the top.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  op_e           op_i,
  output logic [DW-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_MUL:  y_o = a_i * b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SHL:  y_o = a_i << b_i[3:0];
      OP_SHR:  y_o = a_i >> b_i[3:0];
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Evaluates postfix token streams by driving an external LIFO stack and
// returning the value or an error code once the stack has been drained.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  rpn_sequencer_if.master  bus
);

  localparam logic [CW-1:0] DEPTH_MAX = CW'(STK_DEPTH);
  localparam logic [CW-1:0] DEPTH_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_TWO = CW'(2);

  state_e        state_q;
  logic [CW-1:0] depth_q, depth_d;
  logic [DW-1:0] a_q, b_q, result_q;
  op_e           op_q;
  err_e          err_q;

  tok_type_e     tok_type;
  logic          is_end;
  logic          push, pop, tok_ready;
  logic [DW-1:0] din, alu_y;
  logic          in_result;

  assign tok_type = tok_type_e'(bus.tok_type);
  assign is_end   = (tok_type == TOK_END) || (tok_type == TOK_RSVD);

  rpn_alu #(.DW(DW)) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  // Stack commands are decoded from the current state so a token's push or
  // pop lands on the same edge that accepts it; held off entirely in reset.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    din       = '0;
    tok_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          tok_ready = 1'b1;
          if (bus.tok_valid) begin
            if (tok_type == TOK_OPND && depth_q < DEPTH_MAX) begin
              push = 1'b1;
              din  = bus.tok_data;
            end else if (is_end && depth_q == DEPTH_ONE) begin
              pop = 1'b1;
            end
          end
        end
        ST_POP_B, ST_POP_A: pop = 1'b1;
        ST_PUSH_R: begin
          push = 1'b1;
          din  = alu_y;
        end
        ST_SKIP:  tok_ready = 1'b1;
        ST_FLUSH: pop = (depth_q != '0);
        default: ;
      endcase
    end
  end

  always_comb begin
    depth_d = depth_q;
    if (push && depth_q != DEPTH_MAX)  depth_d = depth_q + DEPTH_ONE;
    else if (pop && depth_q != '0)     depth_d = depth_q - DEPTH_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      depth_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      err_q    <= ERR_OK;
    end else begin
      depth_q <= depth_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.tok_valid) begin
            case (tok_type)
              TOK_OPND: begin
                if (depth_q >= DEPTH_MAX) begin
                  err_q   <= ERR_OVER;
                  state_q <= ST_SKIP;
                end
              end
              TOK_OPER: begin
                op_q <= op_e'(bus.tok_op);
                if (depth_q >= DEPTH_TWO) begin
                  state_q <= ST_POP_B;
                end else begin
                  err_q   <= ERR_UNDER;
                  state_q <= ST_SKIP;
                end
              end
              default: begin
                if (depth_q == DEPTH_ONE) begin
                  result_q <= bus.stk_top;
                  err_q    <= ERR_OK;
                end else begin
                  err_q <= ERR_BAD_END;
                end
                state_q <= ST_FLUSH;
              end
            endcase
          end
        end
        ST_POP_B: begin
          b_q     <= bus.stk_top;
          state_q <= ST_POP_A;
        end
        ST_POP_A: begin
          a_q     <= bus.stk_top;
          state_q <= ST_PUSH_R;
        end
        ST_PUSH_R: state_q <= ST_IDLE;
        ST_SKIP: begin
          if (bus.tok_valid && is_end) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (depth_q == '0) state_q <= ST_RESULT;
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            err_q    <= ERR_OK;
            result_q <= '0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_result     = rst_n && (state_q == ST_RESULT);
  assign bus.tok_ready = tok_ready;
  assign bus.stk_push  = push;
  assign bus.stk_pop   = pop;
  assign bus.stk_din   = din;
  assign bus.res_valid = in_result;
  assign bus.res_data  = (in_result && err_q == ERR_OK) ? result_q : '0;
  assign bus.res_err   = in_result ? err_q : ERR_OK;
  assign bus.busy      = rst_n && (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;
  assign bus.dbg_depth = depth_q;

endmodule
